// File: rtl/sram_arbiter.sv
// Two-requester round-robin sequencer for one single-port synchronous sram (registered read).
// Optional per-requester grant counters are enabled by defining SRAM_ARB_STATS_EN.
module sram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_a_req,
    input  logic                  i_a_write,
    input  logic [ADDR_WIDTH-1:0] i_a_addr,
    input  logic [DATA_WIDTH-1:0] i_a_wdata,
    output logic                  o_a_ack,
    output logic [DATA_WIDTH-1:0] o_a_rdata,
    input  logic                  i_b_req,
    input  logic                  i_b_write,
    input  logic [ADDR_WIDTH-1:0] i_b_addr,
    input  logic [DATA_WIDTH-1:0] i_b_wdata,
    output logic                  o_b_ack,
    output logic [DATA_WIDTH-1:0] o_b_rdata,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_write,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [15:0]           o_a_grants,
    output logic [15:0]           o_b_grants
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RCAP, ACK} state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;   // 0 = A, 1 = B
    logic                  last_q, last_d;     // requester granted most recently
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_write_q, mem_write_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  a_ack_q, a_ack_d;
    logic                  b_ack_q, b_ack_d;
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
    logic                  grant;
    logic                  win_b;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        mem_addr_d  = mem_addr_q;
        mem_write_d = mem_write_q;
        mem_wdata_d = mem_wdata_q;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        grant       = 1'b0;
        // Under contention B wins unless B was the last one served.
        win_b       = i_b_req & (~i_a_req | ~last_q);

        case (state_q)
            IDLE: begin
                mem_write_d = 1'b0;
                if (i_a_req || i_b_req) begin
                    grant       = 1'b1;
                    owner_d     = win_b;
                    last_d      = win_b;
                    mem_addr_d  = win_b ? i_b_addr  : i_a_addr;
                    mem_wdata_d = win_b ? i_b_wdata : i_a_wdata;
                    mem_write_d = win_b ? i_b_write : i_a_write;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                if (mem_write_q) begin
                    mem_write_d = 1'b0;
                    a_ack_d     = ~owner_q;
                    b_ack_d     = owner_q;
                    state_d     = ACK;
                end else begin
                    state_d = RCAP;
                end
            end
            RCAP: begin
                if (owner_q) begin
                    b_rdata_d = i_mem_rdata;
                    b_ack_d   = 1'b1;
                end else begin
                    a_rdata_d = i_mem_rdata;
                    a_ack_d   = 1'b1;
                end
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                mem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_write_q <= 1'b0;
            mem_wdata_q <= '0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            mem_addr_q  <= mem_addr_d;
            mem_write_q <= mem_write_d;
            mem_wdata_q <= mem_wdata_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

    assign o_mem_addr  = mem_addr_q;
    assign o_mem_write = mem_write_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_a_ack     = a_ack_q;
    assign o_b_ack     = b_ack_q;
    assign o_a_rdata   = a_rdata_q;
    assign o_b_rdata   = b_rdata_q;

`ifdef SRAM_ARB_STATS_EN
    logic [15:0] a_grants_q, a_grants_d;
    logic [15:0] b_grants_q, b_grants_d;

    // Saturating counts of grant edges per requester.
    always_comb begin
        a_grants_d = a_grants_q;
        b_grants_d = b_grants_q;
        if (grant && !win_b && a_grants_q != 16'hFFFF) begin
            a_grants_d = a_grants_q + 16'd1;
        end
        if (grant && win_b && b_grants_q != 16'hFFFF) begin
            b_grants_d = b_grants_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_grants_q <= 16'd0;
            b_grants_q <= 16'd0;
        end else begin
            a_grants_q <= a_grants_d;
            b_grants_q <= b_grants_d;
        end
    end

    assign o_a_grants = a_grants_q;
    assign o_b_grants = b_grants_q;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: drivers push expected rdata per ack into queues,
// a negedge monitor pops and compares; latencies are checked by the drivers.
module tb_sram_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_req = 1'b0, a_write = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          a_ack;
    logic [DW-1:0] a_rdata;
    logic          b_req = 1'b0, b_write = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          b_ack;
    logic [DW-1:0] b_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_write;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
`ifdef SRAM_ARB_STATS_EN
    logic [15:0]   a_grants, b_grants;
`endif

    sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_a_req     (a_req),
        .i_a_write   (a_write),
        .i_a_addr    (a_addr),
        .i_a_wdata   (a_wdata),
        .o_a_ack     (a_ack),
        .o_a_rdata   (a_rdata),
        .i_b_req     (b_req),
        .i_b_write   (b_write),
        .i_b_addr    (b_addr),
        .i_b_wdata   (b_wdata),
        .o_b_ack     (b_ack),
        .o_b_rdata   (b_rdata),
        .o_mem_addr  (mem_addr),
        .o_mem_write (mem_write),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
`ifdef SRAM_ARB_STATS_EN
        ,
        .o_a_grants  (a_grants),
        .o_b_grants  (b_grants)
`endif
    );

    // Clock and sram model (registered read, write-or-read per cycle).
    always #5 clk = ~clk;

    logic [DW-1:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
    end
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] exp_a_q[$];
    logic [DW-1:0] exp_b_q[$];
    int exp_a_grants = 0;
    int exp_b_grants = 0;
    int wr_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One transaction; exp_lat counts edges from the req-sampling edge to ack high.
    task automatic op(input bit is_b, input bit wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                      input int exp_lat);
        int  n;
        bit  acked;
        repeat (2) @(negedge clk);
        if (is_b) begin
            exp_b_q.push_back(exp_rdata);
            exp_b_grants++;
            b_write = wr; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
        end else begin
            exp_a_q.push_back(exp_rdata);
            exp_a_grants++;
            a_write = wr; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
        end
        n = 0;
        acked = 1'b0;
        while (!acked && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            acked = is_b ? b_ack : a_ack;
        end
        if (is_b) b_req = 1'b0;
        else      a_req = 1'b0;
        check(is_b ? "b_ack_seen" : "a_ack_seen", 32'(acked), 32'd1);
        if (acked) check(is_b ? "b_latency" : "a_latency", n, exp_lat);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_write"}, 32'(mem_write), 32'd0);
        check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_a_ack"},     32'(a_ack),     32'd0);
        check({tag, "_b_ack"},     32'(b_ack),     32'd0);
        check({tag, "_a_rdata"},   32'(a_rdata),   32'd0);
        check({tag, "_b_rdata"},   32'(b_rdata),   32'd0);
`ifdef SRAM_ARB_STATS_EN
        check({tag, "_a_grants"},  32'(a_grants),  32'd0);
        check({tag, "_b_grants"},  32'(b_grants),  32'd0);
`endif
    endtask

    // Monitor: pops expected rdata on every ack, checks ack exclusivity and write strobe width.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_ack || b_ack) check("ack_exclusive", 32'(a_ack & b_ack), 32'd0);
            if (a_ack) begin
                check("a_ack_expected", 32'(exp_a_q.size() != 0), 32'd1);
                if (exp_a_q.size() != 0) check("a_rdata", 32'(a_rdata), 32'(exp_a_q.pop_front()));
            end
            if (b_ack) begin
                check("b_ack_expected", 32'(exp_b_q.size() != 0), 32'd1);
                if (exp_b_q.size() != 0) check("b_rdata", 32'(b_rdata), 32'(exp_b_q.pop_front()));
            end
            if (mem_write) begin
                wr_run++;
            end else if (wr_run != 0) begin
                check("mem_write_width", wr_run, 32'd1);
                wr_run = 0;
            end
        end else begin
            wr_run = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Contention straight out of reset: B wins first, then alternation.
        fork
            op(1'b0, 1'b1, 8'h01, 8'h11, 8'h00, 5);
            op(1'b1, 1'b1, 8'h02, 8'h22, 8'h00, 2);
        join
        fork
            op(1'b0, 1'b0, 8'h01, 8'h00, 8'h11, 7);
            op(1'b1, 1'b0, 8'h02, 8'h00, 8'h22, 3);
        join

        // B streams reads while A issues one write: grants go B, A, B.
        fork
            op(1'b0, 1'b1, 8'h03, 8'h33, 8'h11, 6);
            begin
                op(1'b1, 1'b0, 8'h02, 8'h00, 8'h22, 3);
                op(1'b1, 1'b0, 8'h02, 8'h00, 8'h22, 6);
                op(1'b1, 1'b0, 8'h02, 8'h00, 8'h22, 3);
            end
        join

        // Plain write then read-back.
        op(1'b0, 1'b1, 8'h10, 8'hA5, 8'h11, 2);
        op(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 3);
        op(1'b0, 1'b0, 8'h03, 8'h00, 8'h33, 3);

        // rdata survives a write completion.
        op(1'b0, 1'b1, 8'h40, 8'h5A, 8'h33, 2);
        op(1'b0, 1'b0, 8'h40, 8'h00, 8'h5A, 3);
        op(1'b0, 1'b1, 8'h41, 8'h77, 8'h5A, 2);

        // Reset in the EXEC cycle of a write drops it without an ack.
        repeat (2) @(negedge clk);
        a_write = 1'b1; a_addr = 8'h30; a_wdata = 8'h99; a_req = 1'b1;
        @(posedge clk);
        #1;
        check("exec_mem_write", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_mem_write_clear", 32'(mem_write), 32'd0);
        a_req = 1'b0;
        exp_a_grants = 0;
        exp_b_grants = 0;
        repeat (3) @(negedge clk);
        check_reset_values("midop_reset");
        rst_n = 1'b1;
        op(1'b0, 1'b0, 8'h30, 8'h00, 8'h00, 3);

        // Grant counting: three A grants, two B grants since reset.
        op(1'b0, 1'b1, 8'h50, 8'h01, 8'h00, 2);
        op(1'b1, 1'b1, 8'h51, 8'h02, 8'h00, 2);
        op(1'b0, 1'b0, 8'h50, 8'h00, 8'h01, 3);
        op(1'b1, 1'b0, 8'h51, 8'h00, 8'h02, 3);
`ifdef SRAM_ARB_STATS_EN
        #1;
        check("a_grants", 32'(a_grants), 32'(exp_a_grants));
        check("b_grants", 32'(b_grants), 32'(exp_b_grants));
`endif

        repeat (4) @(negedge clk);
        check("a_queue_drained", exp_a_q.size(), 32'd0);
        check("b_queue_drained", exp_b_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester round-robin arbiter/sequencer that shares one single-port synchronous sram instance (registered read, write-or-read per cycle) between requesters A and B.
- Each requester uses a req/ack handshake. The block drives the sram address, write and data pins, captures read data and returns it with an ack pulse.
- Sits directly in front of the sram; requesters never drive the sram pins themselves.

Parameters:
- ADDR_WIDTH, 8, sram address width.
- DATA_WIDTH, 8, sram data width.

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_a_req  in  1  requester A request; held high until ack.
- i_a_write  in  1  A operation: 1=write, 0=read; stable while i_a_req high.
- i_a_addr  in  ADDR_WIDTH  A address; stable while i_a_req high.
- i_a_wdata  in  DATA_WIDTH  A write data; stable while i_a_req high.
- o_a_ack  out  1  one-cycle completion pulse to A.
- o_a_rdata  out  DATA_WIDTH  A read data; valid while o_a_ack high after a read.
- i_b_req, i_b_write, i_b_addr, i_b_wdata, o_b_ack, o_b_rdata: identical to A, for requester B.
- o_mem_addr  out  ADDR_WIDTH  to sram address, registered.
- o_mem_write  out  1  to sram write strobe, registered.
- o_mem_wdata  out  DATA_WIDTH  to sram write data, registered.
- i_mem_rdata  in  DATA_WIDTH  from sram registered read data.

Behaviour:
- Reset (async, while i_rst_n=0):
  - state=IDLE; o_mem_write=0; o_mem_addr=0; o_mem_wdata=0.
  - o_a_ack=o_b_ack=0; o_a_rdata=o_b_rdata=0.
  - Priority pointer = A; owner = A.
- FSM states: IDLE, EXEC, RCAP, ACK.
- IDLE:
  - At each edge, if any req is high, pick a winner, latch owner, load o_mem_addr/o_mem_wdata from the winner, set o_mem_write=winner's write bit, and go to EXEC.
  - No req: stay in IDLE with o_mem_write=0.
- Arbitration:
  - Single req: that requester wins.
  - Both reqs: the requester not served last wins (pointer toggles to the winner on each grant).
  - Pointer resets to A, so B wins the first contended grant.
- EXEC (one cycle): the sram executes the command at the next edge.
  - Write: at that edge clear o_mem_write, pulse the owner's ack, go to ACK.
  - Read: go to RCAP; o_mem_write stays 0.
- RCAP: at the edge, capture i_mem_rdata into the owner's rdata register, set the owner's ack, go to ACK.
- ACK: ack high for exactly one cycle; next edge clears ack and returns to IDLE. Requests are not sampled in ACK, so the requester drops req on the edge ending ack.
- Latency from the req-sampling edge to ack high:
  - Write: 2 edges.
  - Read: 3 edges.
  - Throughput: one write per 3 cycles, one read per 4.
- Rdata: o_x_rdata holds its last captured value until the next read completes for that requester. Write completions leave rdata unchanged.
- Non-owner ack is never asserted; both acks high at once is illegal.
- o_mem_addr holds its value outside EXEC (idle sram reads are harmless). o_mem_write=1 only in EXEC for writes.
- Reset mid-operation: async reset forces o_mem_write=0 immediately.
  - A write whose EXEC edge has not yet occurred is dropped.
  - No ack is issued; the requester must re-request.
- Reqs that change while not granted are tolerated. A req that drops before grant is simply not served.

Optional Feature:
- Macro SRAM_ARB_STATS_EN.
- Defined: adds outputs o_a_grants and o_b_grants, 16 bits each, reset to 0. Each increments on that requester's grant edge, saturating at 16'hFFFF.
- Undefined: these ports and counters do not exist. Remaining behaviour is identical.

Test Plan:
- A write addr 8'h10 data 8'hA5, then A read 8'h10 -> o_a_ack 2 edges after write req, then 3 edges after read req with o_a_rdata=8'hA5; o_mem_write high exactly one cycle.
- A and B both request from IDLE after reset (A write 8'h01=8'h11, B write 8'h02=8'h22), held -> B granted first, then A; alternation continues; subsequent reads return 8'h11 and 8'h22.
- B holds continuous reads while A issues one write -> grants alternate B,A,B; A never starved beyond one B transaction.
- Assert i_rst_n=0 during EXEC of an A write to 8'h30 (prior contents 8'h00) -> o_mem_write drops asynchronously, no ack; later read of 8'h30 returns 8'h00.
- A read completes with 8'h5A, then A write -> o_a_rdata stays 8'h5A through the write ack; o_b_ack never pulses.
- With SRAM_ARB_STATS_EN: 3 A grants, 2 B grants -> o_a_grants=3, o_b_grants=2; both reset to 0 on i_rst_n=0.
